spi_slave: RTL

SPI_SLAVE -- requirements
Module: spi_slave

---
 rtl/spi_slave.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/spi_slave.sv
//==============================================================================
// Module      : spi_slave
// Description : SPI mode-0 slave, MSB first, oversampled on clk, with a
//               one-word tx holding buffer and a one-word rx output register.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module spi_slave #(
    parameter int W_DATA = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    input  logic [W_DATA-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [W_DATA-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ack,
    output logic              rx_overrun,
    output logic              busy
);

    localparam int CW = $clog2(W_DATA);
    localparam logic [CW-1:0] c_last = CW'(W_DATA - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t            r_state;
    logic              r_sclk_s1, r_sclk_s2, r_sclk_s3;
    logic              r_cs_s1, r_cs_s2, r_cs_s3;
    logic              r_mosi_s1, r_mosi_s2;
    logic [CW-1:0]     r_bit_cnt;
    logic [W_DATA-1:0] r_tx_sr;
    logic [W_DATA-2:0] r_rx_sr;
    logic [W_DATA-1:0] r_buf;
    logic              r_buf_empty;
    logic              r_miso;
    logic [W_DATA-1:0] r_rx_data;
    logic              r_rx_valid;
    logic              r_rx_overrun;
    logic              r_busy;

    logic              w_sclk_rise, w_sclk_fall, w_cs_fall, w_cs_rise;
    logic              w_word_done, w_load, w_wr;
    logic [W_DATA-1:0] w_rx_word, w_tx_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sclk_s1 <= 1'b0;
            r_sclk_s2 <= 1'b0;
            r_sclk_s3 <= 1'b0;
            r_cs_s1   <= 1'b1;
            r_cs_s2   <= 1'b1;
            r_cs_s3   <= 1'b1;
            r_mosi_s1 <= 1'b0;
            r_mosi_s2 <= 1'b0;
        end else begin
            r_sclk_s1 <= sclk;
            r_sclk_s2 <= r_sclk_s1;
            r_sclk_s3 <= r_sclk_s2;
            r_cs_s1   <= cs_n;
            r_cs_s2   <= r_cs_s1;
            r_cs_s3   <= r_cs_s2;
            r_mosi_s1 <= mosi;
            r_mosi_s2 <= r_mosi_s1;
        end
    end

    assign w_sclk_rise = r_sclk_s2 & ~r_sclk_s3;
    assign w_sclk_fall = ~r_sclk_s2 & r_sclk_s3;
    assign w_cs_fall   = ~r_cs_s2 & r_cs_s3;
    assign w_cs_rise   = r_cs_s2 & ~r_cs_s3;

    assign w_rx_word   = {r_rx_sr, r_mosi_s2};
    assign w_word_done = (r_state == SHIFT) && !w_cs_rise && w_sclk_rise && (r_bit_cnt == c_last);
    assign w_load      = ((r_state == IDLE) && w_cs_fall) || w_word_done;
    assign w_tx_next   = r_buf_empty ? '0 : r_buf;
    assign w_wr        = tx_valid && r_buf_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_busy       <= 1'b0;
            r_bit_cnt    <= '0;
            r_tx_sr      <= '0;
            r_rx_sr      <= '0;
            r_buf        <= '0;
            r_buf_empty  <= 1'b1;
            r_miso       <= 1'b0;
            r_rx_data    <= '0;
            r_rx_valid   <= 1'b0;
            r_rx_overrun <= 1'b0;
        end else begin
            r_rx_overrun <= 1'b0;
            if (w_word_done) begin
                if (!r_rx_valid || rx_ack) begin
                    r_rx_data  <= w_rx_word;
                    r_rx_valid <= 1'b1;
                end else begin
                    r_rx_overrun <= 1'b1;
                end
            end else if (rx_ack) begin
                r_rx_valid <= 1'b0;
            end

            // A write only lands in an empty buffer, so a simultaneous load
            // (which took the old, empty contents) leaves it full.
            if (w_wr) begin
                r_buf       <= tx_data;
                r_buf_empty <= 1'b0;
            end else if (w_load) begin
                r_buf_empty <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (w_cs_fall) begin
                        r_state   <= SHIFT;
                        r_busy    <= 1'b1;
                        r_tx_sr   <= w_tx_next;
                        r_bit_cnt <= '0;
                    end
                end
                SHIFT: begin
                    if (w_cs_rise) begin
                        r_state   <= IDLE;
                        r_busy    <= 1'b0;
                        r_bit_cnt <= '0;
                    end else if (w_sclk_rise) begin
                        r_rx_sr <= w_rx_word[W_DATA-2:0];
                        if (r_bit_cnt == c_last) begin
                            r_bit_cnt <= '0;
                            r_tx_sr   <= w_tx_next;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end else if (w_sclk_fall && (r_bit_cnt != '0)) begin
                        // The fall following a word boundary must not shift out
                        // the MSB of the freshly loaded word.
                        r_tx_sr <= {r_tx_sr[W_DATA-2:0], 1'b0};
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase

            r_miso <= (r_state == SHIFT) ? r_tx_sr[W_DATA-1] : 1'b0;
        end
    end

    assign miso       = r_miso;
    assign tx_ready   = r_buf_empty;
    assign rx_data    = r_rx_data;
    assign rx_valid   = r_rx_valid;
    assign rx_overrun = r_rx_overrun;
    assign busy       = r_busy;

endmodule

`default_nettype wire
